// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared types, key count and ms-to-cycle helper for key_event_gen
package key_event_pkg;

   localparam int NKEYS = 4;

   typedef enum logic [1:0] {
      EV_PRESS   = 2'd0,
      EV_LONG    = 2'd1,
      EV_REPEAT  = 2'd2,
      EV_RELEASE = 2'd3
   } ev_type_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DOWN     = 2'd1,
      REPT     = 2'd2,
      WAIT_REL = 2'd3
   } key_state_e;

   function automatic int ms_to_cyc(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchroniser and debounce counter for one active-low key
module key_debounce #(
   parameter int DB_CYC = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic held
);

   localparam int CW = $clog2(DB_CYC + 1);

   logic [1:0]    sync_n;
   logic          s;
   logic [CW-1:0] cnt;

   assign s = ~sync_n[1];

   // Sync flops reset to 1 so a key is seen as released until proven otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_n <= 2'b11;
         cnt    <= '0;
         held   <= 1'b0;
      end else begin
         sync_n <= {sync_n[0], key_n};
         if (s == held) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYC - 1)) begin
            held <= s;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - debounced key event source (PRESS/LONG/REPEAT/RELEASE), one event per cycle
// Optional: define KEY_RELEASE_EV_EN to emit RELEASE events.
module key_event_gen
   import key_event_pkg::*;
#(
   parameter int CLK_HZ      = 50000000,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] key_n,
   output logic [3:0] held,
   output logic       ev_valid,
   output logic [1:0] ev_key,
   output logic [1:0] ev_type
);

   localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
   localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
   localparam int REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
   localparam int HMAX     = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
   localparam int HW       = $clog2(HMAX + 1);

   key_state_e              state [NKEYS];
   logic [HW-1:0]           hcnt  [NKEYS];
   logic [NKEYS-1:0][3:0]   pend;
   logic [NKEYS-1:0][3:0]   post;
   logic [NKEYS-1:0][3:0]   clr;
   logic                    sel_valid;
   logic [1:0]              sel_key;
   logic [1:0]              sel_type;

   for (genvar g = 0; g < NKEYS; g++) begin : g_db
      key_debounce #(.DB_CYC(DB_CYC)) u_db (
         .clk   (clk),
         .reset (reset),
         .key_n (key_n[g]),
         .held  (held[g])
      );
   end

   always_comb begin
      post = '0;
      for (int i = 0; i < NKEYS; i++) begin
         case (state[i])
            IDLE: if (held[i]) post[i][EV_PRESS] = 1'b1;
            DOWN: begin
               if (!held[i]) begin
`ifdef KEY_RELEASE_EV_EN
                  post[i][EV_RELEASE] = 1'b1;
`endif
               end else if (hcnt[i] == HW'(LONG_CYC - 1)) begin
                  post[i][EV_LONG] = 1'b1;
               end
            end
            REPT: begin
               if (!held[i]) begin
`ifdef KEY_RELEASE_EV_EN
                  post[i][EV_RELEASE] = 1'b1;
`endif
               end else if (hcnt[i] == HW'(REP_CYC - 1)) begin
                  post[i][EV_REPEAT] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Scan from the top down so the lowest key, then lowest type, wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_key   = '0;
      sel_type  = '0;
      clr       = '0;
      for (int k = NKEYS - 1; k >= 0; k--) begin
         for (int t = 3; t >= 0; t--) begin
            if (pend[k][t]) begin
               sel_valid = 1'b1;
               sel_key   = 2'(k);
               sel_type  = 2'(t);
            end
         end
      end
      if (sel_valid) clr[sel_key][sel_type] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NKEYS; i++) begin
            state[i] <= IDLE;
            hcnt[i]  <= '0;
         end
         pend     <= '0;
         ev_valid <= 1'b0;
         ev_key   <= '0;
         ev_type  <= '0;
      end else if (!enable) begin
         // A key still down when gating lifts must be released before it can PRESS again.
         for (int i = 0; i < NKEYS; i++) begin
            state[i] <= held[i] ? WAIT_REL : IDLE;
            hcnt[i]  <= '0;
         end
         pend     <= '0;
         ev_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NKEYS; i++) begin
            case (state[i])
               IDLE: begin
                  if (held[i]) begin
                     state[i] <= DOWN;
                     hcnt[i]  <= '0;
                  end
               end
               DOWN: begin
                  if (!held[i]) begin
                     state[i] <= IDLE;
                  end else if (hcnt[i] == HW'(LONG_CYC - 1)) begin
                     state[i] <= REPT;
                     hcnt[i]  <= '0;
                  end else begin
                     hcnt[i] <= hcnt[i] + 1'b1;
                  end
               end
               REPT: begin
                  if (!held[i]) begin
                     state[i] <= IDLE;
                  end else if (hcnt[i] == HW'(REP_CYC - 1)) begin
                     hcnt[i] <= '0;
                  end else begin
                     hcnt[i] <= hcnt[i] + 1'b1;
                  end
               end
               WAIT_REL: if (!held[i]) state[i] <= IDLE;
               default:  state[i] <= IDLE;
            endcase
         end
         pend     <= (pend & ~clr) | post;
         ev_valid <= sel_valid;
         if (sel_valid) begin
            ev_key  <= sel_key;
            ev_type <= sel_type;
         end
      end
   end

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - directed-vector self-checking bench for key_event_gen
module tb_key_event_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] key_n;
   logic [3:0] held;
   logic       ev_valid;
   logic [1:0] ev_key;
   logic [1:0] ev_type;

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int saw_rel = 0;
   int lc[$];
   int lk[$];
   int lt[$];
   int t0, t1, t2, t3;

   key_event_gen #(
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4),
      .LONG_MS     (20),
      .REPEAT_MS   (5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .key_n    (key_n),
      .held     (held),
      .ev_valid (ev_valid),
      .ev_key   (ev_key),
      .ev_type  (ev_type)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ev_valid === 1'b1) begin
         lc.push_back(cyc);
         lk.push_back(int'(ev_key));
         lt.push_back(int'(ev_type));
         if (ev_type == 2'd3) saw_rel = 1;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic exp_ev(input string tag, input int idx, input int c, input int k, input int t);
      if (idx < lc.size()) begin
         check({tag, "_cyc"},  lc[idx], c);
         check({tag, "_key"},  lk[idx], k);
         check({tag, "_type"}, lt[idx], t);
      end else begin
         check({tag, "_missing"}, lc.size(), idx + 1);
      end
   endtask

   task automatic clr_log();
      lc.delete();
      lk.delete();
      lt.delete();
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      key_n  = 4'hF;
      wait_cyc(2);
      check("rst_held",     int'(held),     0);
      check("rst_ev_valid", int'(ev_valid), 0);
      check("rst_ev_key",   int'(ev_key),   0);
      check("rst_ev_type",  int'(ev_type),  0);
      reset = 1'b0;
      wait_cyc(5);

      // 3-cycle glitch is shorter than the debounce window
      clr_log();
      key_n[0] = 1'b0;
      wait_cyc(3);
      key_n[0] = 1'b1;
      check("glitch_held_mid", int'(held), 0);
      wait_cyc(20);
      check("glitch_held", int'(held), 0);
      check("glitch_events", lc.size(), 0);

      // short press on key 1
      clr_log();
      t0 = cyc + 1;
      key_n[1] = 1'b0;
      wait_cyc(8);
      check("k1_held", int'(held), 2);
      wait_cyc(4);
      key_n[1] = 1'b1;
      t1 = cyc + 1;
      wait_cyc(15);
      check("k1_held_after", int'(held), 0);
      exp_ev("k1_press", 0, t0 + 7, 1, 0);
`ifdef KEY_RELEASE_EV_EN
      exp_ev("k1_rel", 1, t1 + 7, 1, 3);
      check("k1_count", lc.size(), 2);
`else
      check("k1_count", lc.size(), 1);
`endif

      // long hold on key 2: PRESS, LONG, 3x REPEAT
      clr_log();
      t0 = cyc + 1;
      key_n[2] = 1'b0;
      wait_cyc(40);
      key_n[2] = 1'b1;
      t1 = cyc + 1;
      wait_cyc(15);
      exp_ev("k2_press", 0, t0 + 7,  2, 0);
      exp_ev("k2_long",  1, t0 + 27, 2, 1);
      exp_ev("k2_rep1",  2, t0 + 32, 2, 2);
      exp_ev("k2_rep2",  3, t0 + 37, 2, 2);
      exp_ev("k2_rep3",  4, t0 + 42, 2, 2);
`ifdef KEY_RELEASE_EV_EN
      exp_ev("k2_rel", 5, t1 + 7, 2, 3);
      check("k2_count", lc.size(), 6);
`else
      check("k2_count", lc.size(), 5);
`endif

      // keys 0 and 3 on the same edge drain in priority order
      clr_log();
      t0 = cyc + 1;
      key_n = 4'b0110;
      wait_cyc(10);
      key_n = 4'hF;
      t1 = cyc + 1;
      wait_cyc(15);
      exp_ev("k03_p0", 0, t0 + 7, 0, 0);
      exp_ev("k03_p3", 1, t0 + 8, 3, 0);
`ifdef KEY_RELEASE_EV_EN
      exp_ev("k03_r0", 2, t1 + 7, 0, 3);
      exp_ev("k03_r3", 3, t1 + 8, 3, 3);
      check("k03_count", lc.size(), 4);
`else
      check("k03_count", lc.size(), 2);
`endif

      // enable gating with key 1 held across the gap
      clr_log();
      t0 = cyc + 1;
      key_n[1] = 1'b0;
      wait_cyc(10);
      enable = 1'b0;
      wait_cyc(10);
      check("en_low_held", int'(held), 2);
      enable = 1'b1;
      wait_cyc(10);
      check("en_regate_count", lc.size(), 1);
      key_n[1] = 1'b1;
      wait_cyc(15);
      check("en_waitrel_count", lc.size(), 1);
      t2 = cyc + 1;
      key_n[1] = 1'b0;
      wait_cyc(10);
      key_n[1] = 1'b1;
      t3 = cyc + 1;
      wait_cyc(15);
      exp_ev("en_press1", 0, t0 + 7, 1, 0);
      exp_ev("en_press2", 1, t2 + 7, 1, 0);
`ifdef KEY_RELEASE_EV_EN
      exp_ev("en_rel", 2, t3 + 7, 1, 3);
      check("en_count", lc.size(), 3);
`else
      check("en_count", lc.size(), 2);
`endif

      // async reset in the middle of the repeat phase
      clr_log();
      t0 = cyc + 1;
      key_n[2] = 1'b0;
      wait_cyc(36);
      check("mid_held", int'(held), 4);
      reset = 1'b1;
      #1;
      check("arst_held",     int'(held),     0);
      check("arst_ev_valid", int'(ev_valid), 0);
      check("arst_ev_key",   int'(ev_key),   0);
      check("arst_ev_type",  int'(ev_type),  0);
      wait_cyc(3);
      reset = 1'b0;
      clr_log();
      t0 = cyc + 1;
      wait_cyc(10);
      key_n[2] = 1'b1;
      t1 = cyc + 1;
      wait_cyc(15);
      exp_ev("rst_press", 0, t0 + 7, 2, 0);
`ifdef KEY_RELEASE_EV_EN
      exp_ev("rst_rel", 1, t1 + 7, 2, 3);
      check("rst_count", lc.size(), 2);
      check("release_seen", saw_rel, 1);
`else
      check("rst_count", lc.size(), 1);
      check("no_release_type", saw_rel, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
